// File: rtl/vectored_interrupt_controller.sv
// ---------------------------------------------------------------------------
// vectored_interrupt_controller
//
// Parametrised N-channel vectored interrupt controller. Rising edges on INT
// are latched into PENDING; the lowest-index pending channel that is enabled
// in the mask is the candidate. Acceptance is only evaluated on a clock edge
// with COMMIT=1, using the enable/state values from before that edge. On
// acceptance the controller pulses PC_LD_INTX for one cycle together with
// INT_VECTOR = VECTOR_BASE + id * VECTOR_STRIDE.
//
// Optional build macro: INT_NESTING_EN
//   Undefined (default): single service level, entry clears IE, RETIX
//                        returns to idle and sets IE.
//   Defined            : entry leaves IE alone, a higher-priority candidate
//                        preempts the running ISR (up to NEST_DEPTH stacked
//                        levels), RETIX pops the stack.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-low reset
//   COMMIT      in   instruction commit strobe; qualifies EIX/DIX/RETIX
//   EIX         in   enable-interrupts decode
//   DIX         in   disable-interrupts decode (wins over EIX)
//   RETIX       in   return-from-interrupt decode
//   INT         in   [N_CHANNELS] request lines, synchronous to CLK
//   MASK_WE     in   mask write strobe (independent of COMMIT)
//   MASK_D      in   [N_CHANNELS] mask write data, 1 = channel enabled
//   PC_LD_INTX  out  one-cycle program-counter load pulse
//   INT_VECTOR  out  [ADDR_WIDTH] vector address, valid with PC_LD_INTX
//   IE          out  global interrupt enable
//   INT_ACTIVE  out  an ISR is in service
//   ACTIVE_ID   out  [clog2(N_CHANNELS)] channel in service
//   PENDING     out  [N_CHANNELS] latched pending requests
// ---------------------------------------------------------------------------
module vectored_interrupt_controller #(
  parameter int                    N_CHANNELS    = 4,
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE   = 16'h0010,
  parameter int                    VECTOR_STRIDE = 4,
  parameter int                    NEST_DEPTH    = 4,
  localparam int                   ID_W          = $clog2(N_CHANNELS)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  COMMIT,
  input  logic                  EIX,
  input  logic                  DIX,
  input  logic                  RETIX,
  input  logic [N_CHANNELS-1:0] INT,
  input  logic                  MASK_WE,
  input  logic [N_CHANNELS-1:0] MASK_D,
  output logic                  PC_LD_INTX,
  output logic [ADDR_WIDTH-1:0] INT_VECTOR,
  output logic                  IE,
  output logic                  INT_ACTIVE,
  output logic [ID_W-1:0]       ACTIVE_ID,
  output logic [N_CHANNELS-1:0] PENDING
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [N_CHANNELS-1:0]   int_prev_reg;
  logic [N_CHANNELS-1:0]   pending_reg;
  logic [N_CHANNELS-1:0]   mask_reg;
  logic                    ie_reg;
  logic                    pc_ld_reg;
  logic [ADDR_WIDTH-1:0]   vector_reg;
  logic                    int_active_reg;
  logic [ID_W-1:0]         active_id_reg;

  logic [N_CHANNELS-1:0]   int_rise;
  logic [N_CHANNELS-1:0]   eligible;
  logic [N_CHANNELS-1:0]   take_clear;
  logic [N_CHANNELS-1:0]   pending_next;
  logic                    cand_valid;
  logic [ID_W-1:0]         cand_id;
  logic [ADDR_WIDTH-1:0]   cand_vector;
  logic                    take_idle;
  logic                    take_preempt;
  logic                    accept;

  assign int_rise = INT & ~int_prev_reg;
  assign eligible = pending_reg & mask_reg;

  // Lowest index wins: scan from the top so the last hit is the smallest id.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        cand_valid = 1'b1;
        cand_id    = ID_W'(i);
      end
    end
  end

  assign cand_vector = VECTOR_BASE + ADDR_WIDTH'(cand_id) * ADDR_WIDTH'(VECTOR_STRIDE);

  // Acceptance looks only at pre-edge IE and state, so EI takes effect one
  // instruction later and RETIX cannot retrigger on its own commit.
  assign take_idle = (state_reg == ST_IDLE) && COMMIT && ie_reg && cand_valid;

`ifdef INT_NESTING_EN
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
  localparam int STK_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [ID_W-1:0]    stack_reg [NEST_DEPTH];
  logic [DEPTH_W-1:0] depth_reg;
  logic [STK_W-1:0]   push_idx;
  logic [STK_W-1:0]   pop_idx;
  logic               stack_full;

  assign push_idx   = STK_W'(depth_reg);
  assign pop_idx    = STK_W'(depth_reg - DEPTH_W'(1));
  assign stack_full = (depth_reg == DEPTH_W'(NEST_DEPTH));

  // A RETIX commit is a return, never a preemption on the same edge.
  assign take_preempt = (state_reg == ST_SERVICE) && COMMIT && !RETIX && ie_reg &&
                        cand_valid && (cand_id < active_id_reg) && !stack_full;

  // The stack is plain storage; emptiness is tracked by depth_reg alone.
  always_ff @(posedge CLK) begin
    if (take_preempt) begin
      stack_reg[push_idx] <= active_id_reg;
    end
  end
`else
  assign take_preempt = 1'b0;
`endif

  assign accept = take_idle || take_preempt;

  // One-hot clear of the accepted channel; a fresh edge in the same cycle
  // re-sets the bit because the OR with int_rise comes last.
  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_clear
    assign take_clear[gi] = accept && (cand_id == ID_W'(gi));
  end

  assign pending_next = (pending_reg & ~take_clear) | int_rise;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= ST_IDLE;
      int_prev_reg   <= '0;
      pending_reg    <= '0;
      mask_reg       <= '1;
      ie_reg         <= 1'b0;
      pc_ld_reg      <= 1'b0;
      vector_reg     <= '0;
      int_active_reg <= 1'b0;
      active_id_reg  <= '0;
`ifdef INT_NESTING_EN
      depth_reg      <= '0;
`endif
    end else begin
      int_prev_reg <= INT;
      pending_reg  <= pending_next;
      if (MASK_WE) begin
        mask_reg <= MASK_D;
      end

      pc_ld_reg  <= accept;
      vector_reg <= accept ? cand_vector : '0;

      if (COMMIT) begin
        if (DIX) begin
          ie_reg <= 1'b0;
        end else if (EIX) begin
          ie_reg <= 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          // RETIX with nothing in service only re-enables interrupts.
          if (COMMIT && RETIX && !DIX) begin
            ie_reg <= 1'b1;
          end
          if (take_idle) begin
            state_reg      <= ST_ENTER;
            int_active_reg <= 1'b1;
            active_id_reg  <= cand_id;
`ifndef INT_NESTING_EN
            ie_reg         <= 1'b0;
`endif
          end
        end

        // The PC load cycle; no acceptance here, so pulses never abut.
        ST_ENTER: begin
          state_reg <= ST_SERVICE;
        end

        ST_SERVICE: begin
          if (COMMIT && RETIX) begin
`ifdef INT_NESTING_EN
            if (depth_reg != '0) begin
              active_id_reg <= stack_reg[pop_idx];
              depth_reg     <= depth_reg - DEPTH_W'(1);
            end else begin
              state_reg      <= ST_IDLE;
              int_active_reg <= 1'b0;
              if (!DIX) begin
                ie_reg <= 1'b1;
              end
            end
`else
            state_reg      <= ST_IDLE;
            int_active_reg <= 1'b0;
            if (!DIX) begin
              ie_reg <= 1'b1;
            end
`endif
          end
`ifdef INT_NESTING_EN
          else if (take_preempt) begin
            state_reg     <= ST_ENTER;
            active_id_reg <= cand_id;
            depth_reg     <= depth_reg + DEPTH_W'(1);
          end
`endif
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign PC_LD_INTX = pc_ld_reg;
  assign INT_VECTOR = vector_reg;
  assign IE         = ie_reg;
  assign INT_ACTIVE = int_active_reg;
  assign ACTIVE_ID  = active_id_reg;
  assign PENDING    = pending_reg;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_vectored_interrupt_controller
//
// Directed self-checking bench for vectored_interrupt_controller with
// N_CHANNELS=4, VECTOR_BASE=0x0010, VECTOR_STRIDE=4. Inputs change 1 time
// unit after the rising edge; outputs are sampled at that same point, i.e.
// after the registers have settled. Builds with or without INT_NESTING_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vectored_interrupt_controller;

  logic        CLK;
  logic        RESET;
  logic        COMMIT;
  logic        EIX;
  logic        DIX;
  logic        RETIX;
  logic [3:0]  INT;
  logic        MASK_WE;
  logic [3:0]  MASK_D;
  logic        PC_LD_INTX;
  logic [15:0] INT_VECTOR;
  logic        IE;
  logic        INT_ACTIVE;
  logic [1:0]  ACTIVE_ID;
  logic [3:0]  PENDING;

  int checks;
  int errors;
  int pc_ld_count;
  int consec_count;
  logic prev_ld;

`ifdef INT_NESTING_EN
  localparam logic IE_AFTER_ENTRY = 1'b1;
`else
  localparam logic IE_AFTER_ENTRY = 1'b0;
`endif

  vectored_interrupt_controller #(
    .N_CHANNELS   (4),
    .ADDR_WIDTH   (16),
    .VECTOR_BASE  (16'h0010),
    .VECTOR_STRIDE(4),
    .NEST_DEPTH   (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .COMMIT    (COMMIT),
    .EIX       (EIX),
    .DIX       (DIX),
    .RETIX     (RETIX),
    .INT       (INT),
    .MASK_WE   (MASK_WE),
    .MASK_D    (MASK_D),
    .PC_LD_INTX(PC_LD_INTX),
    .INT_VECTOR(INT_VECTOR),
    .IE        (IE),
    .INT_ACTIVE(INT_ACTIVE),
    .ACTIVE_ID (ACTIVE_ID),
    .PENDING   (PENDING)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count load pulses and any back-to-back pulse pair.
  initial begin
    pc_ld_count  = 0;
    consec_count = 0;
    prev_ld      = 1'b0;
  end
  always @(negedge CLK) begin
    if (PC_LD_INTX === 1'b1) pc_ld_count = pc_ld_count + 1;
    if (PC_LD_INTX === 1'b1 && prev_ld === 1'b1) consec_count = consec_count + 1;
    prev_ld = PC_LD_INTX;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_commit(input logic e, input logic d, input logic r);
    COMMIT = 1'b1; EIX = e; DIX = d; RETIX = r;
    cyc();
    COMMIT = 1'b0; EIX = 1'b0; DIX = 1'b0; RETIX = 1'b0;
  endtask

  task automatic pulse_int(input logic [3:0] v);
    INT = v;
    cyc();
    INT = 4'b0000;
  endtask

  task automatic write_mask(input logic [3:0] m);
    MASK_WE = 1'b1; MASK_D = m;
    cyc();
    MASK_WE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; COMMIT = 1'b0; EIX = 1'b0; DIX = 1'b0; RETIX = 1'b0;
    INT = 4'b0000; MASK_WE = 1'b0; MASK_D = 4'b0000;
    cyc(); cyc();
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL rst_pcld: got %b expected 0", PC_LD_INTX); end
    checks++; if (INT_VECTOR !== 16'h0000) begin errors++; $display("FAIL rst_vector: got %h expected 0000", INT_VECTOR); end
    checks++; if (IE !== 1'b0) begin errors++; $display("FAIL rst_ie: got %b expected 0", IE); end
    checks++; if (INT_ACTIVE !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", INT_ACTIVE); end
    checks++; if (ACTIVE_ID !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d expected 0", ACTIVE_ID); end
    checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b expected 0000", PENDING); end
    RESET = 1'b1;
    cyc();
    $display("reset released: IE=%b PENDING=%b", IE, PENDING);
  endtask

  task automatic test_basic_entry();
    pulse_int(4'b0100);
    checks++; if (PENDING !== 4'b0100) begin errors++; $display("FAIL basic_pend: got %b expected 0100", PENDING); end
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL basic_no_ld_ie0: got %b expected 0", PC_LD_INTX); end
    do_commit(1'b1, 1'b0, 1'b0);
    checks++; if (IE !== 1'b1) begin errors++; $display("FAIL basic_ei: got %b expected 1", IE); end
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL basic_ei_no_take: got %b expected 0", PC_LD_INTX); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b1) begin errors++; $display("FAIL basic_ld: got %b expected 1", PC_LD_INTX); end
    checks++; if (INT_VECTOR !== 16'h0018) begin errors++; $display("FAIL basic_vector: got %h expected 0018", INT_VECTOR); end
    checks++; if (IE !== IE_AFTER_ENTRY) begin errors++; $display("FAIL basic_ie_entry: got %b expected %b", IE, IE_AFTER_ENTRY); end
    checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL basic_pend_clr: got %b expected 0000", PENDING); end
    checks++; if (ACTIVE_ID !== 2'd2) begin errors++; $display("FAIL basic_id: got %0d expected 2", ACTIVE_ID); end
    checks++; if (INT_ACTIVE !== 1'b1) begin errors++; $display("FAIL basic_active: got %b expected 1", INT_ACTIVE); end
    cyc();
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL basic_ld_one_cycle: got %b expected 0", PC_LD_INTX); end
    do_commit(1'b0, 1'b0, 1'b1);
    checks++; if (INT_ACTIVE !== 1'b0) begin errors++; $display("FAIL basic_ret_active: got %b expected 0", INT_ACTIVE); end
    checks++; if (IE !== 1'b1) begin errors++; $display("FAIL basic_ret_ie: got %b expected 1", IE); end
    $display("basic entry: vector 0018 taken and returned");
  endtask

  task automatic test_priority();
    pulse_int(4'b1010);
    checks++; if (PENDING !== 4'b1010) begin errors++; $display("FAIL prio_pend: got %b expected 1010", PENDING); end
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (INT_VECTOR !== 16'h0014 || PC_LD_INTX !== 1'b1) begin errors++; $display("FAIL prio_first: got ld=%b vec=%h expected ld=1 vec=0014", PC_LD_INTX, INT_VECTOR); end
    checks++; if (PENDING !== 4'b1000) begin errors++; $display("FAIL prio_pend_left: got %b expected 1000", PENDING); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b1);
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL prio_ret_no_take: got %b expected 0", PC_LD_INTX); end
    checks++; if (IE !== 1'b1 || INT_ACTIVE !== 1'b0) begin errors++; $display("FAIL prio_ret: got ie=%b act=%b expected ie=1 act=0", IE, INT_ACTIVE); end
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (INT_VECTOR !== 16'h001C || PC_LD_INTX !== 1'b1) begin errors++; $display("FAIL prio_second: got ld=%b vec=%h expected ld=1 vec=001c", PC_LD_INTX, INT_VECTOR); end
    checks++; if (ACTIVE_ID !== 2'd3) begin errors++; $display("FAIL prio_id: got %0d expected 3", ACTIVE_ID); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b1);
    $display("priority: 0014 then 001c");
  endtask

  task automatic test_mask();
    write_mask(4'b1110);
    pulse_int(4'b0001);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b expected 0", PC_LD_INTX); end
    checks++; if (PENDING !== 4'b0001) begin errors++; $display("FAIL mask_pend_kept: got %b expected 0001", PENDING); end
    write_mask(4'b1111);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (INT_VECTOR !== 16'h0010 || PC_LD_INTX !== 1'b1) begin errors++; $display("FAIL mask_unmasked: got ld=%b vec=%h expected ld=1 vec=0010", PC_LD_INTX, INT_VECTOR); end
    checks++; if (ACTIVE_ID !== 2'd0) begin errors++; $display("FAIL mask_id: got %0d expected 0", ACTIVE_ID); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b1);
    $display("mask: channel 0 held then taken at 0010");
  endtask

  task automatic test_level_hold();
    int base_count;
    do_commit(1'b1, 1'b1, 1'b0);
    checks++; if (IE !== 1'b0) begin errors++; $display("FAIL eidi_dix_wins: got %b expected 0", IE); end
    base_count = pc_ld_count;
    INT = 4'b0100;
    repeat (10) cyc();
    checks++; if (PENDING !== 4'b0100) begin errors++; $display("FAIL level_pend_once: got %b expected 0100", PENDING); end
    do_commit(1'b1, 1'b0, 1'b0);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (INT_VECTOR !== 16'h0018 || PC_LD_INTX !== 1'b1) begin errors++; $display("FAIL level_take: got ld=%b vec=%h expected ld=1 vec=0018", PC_LD_INTX, INT_VECTOR); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b1);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b0 || PENDING !== 4'b0000) begin errors++; $display("FAIL level_no_repend: got ld=%b pend=%b expected ld=0 pend=0000", PC_LD_INTX, PENDING); end
    INT = 4'b0000;
    cyc();
    checks++; if (pc_ld_count - base_count !== 1) begin errors++; $display("FAIL level_entries: got %0d expected 1", pc_ld_count - base_count); end
    $display("level hold: entries=%0d", pc_ld_count - base_count);
  endtask

  task automatic test_back_to_back();
    pulse_int(4'b0100);
    cyc();
    INT = 4'b0100; COMMIT = 1'b1;
    cyc();
    INT = 4'b0000; COMMIT = 1'b0;
    checks++; if (PC_LD_INTX !== 1'b1 || INT_VECTOR !== 16'h0018) begin errors++; $display("FAIL b2b_take: got ld=%b vec=%h expected ld=1 vec=0018", PC_LD_INTX, INT_VECTOR); end
    checks++; if (PENDING !== 4'b0100) begin errors++; $display("FAIL b2b_set_wins: got %b expected 0100", PENDING); end
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL b2b_no_consecutive: got %b expected 0", PC_LD_INTX); end
    do_commit(1'b0, 1'b0, 1'b1);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b1 || PENDING !== 4'b0000) begin errors++; $display("FAIL b2b_retake: got ld=%b pend=%b expected ld=1 pend=0000", PC_LD_INTX, PENDING); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b1);
    $display("back to back: re-pended edge retaken");
  endtask

`ifdef INT_NESTING_EN
  task automatic test_nesting();
    pulse_int(4'b0100);
    do_commit(1'b0, 1'b0, 1'b0);
    cyc();
    pulse_int(4'b0001);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b1 || INT_VECTOR !== 16'h0010) begin errors++; $display("FAIL nest_preempt: got ld=%b vec=%h expected ld=1 vec=0010", PC_LD_INTX, INT_VECTOR); end
    checks++; if (ACTIVE_ID !== 2'd0) begin errors++; $display("FAIL nest_id0: got %0d expected 0", ACTIVE_ID); end
    cyc();
    pulse_int(4'b1000);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL nest_low_blocked: got %b expected 0", PC_LD_INTX); end
    do_commit(1'b0, 1'b0, 1'b1);
    checks++; if (ACTIVE_ID !== 2'd2 || INT_ACTIVE !== 1'b1) begin errors++; $display("FAIL nest_pop: got id=%0d act=%b expected id=2 act=1", ACTIVE_ID, INT_ACTIVE); end
    do_commit(1'b0, 1'b0, 1'b1);
    checks++; if (INT_ACTIVE !== 1'b0 || IE !== 1'b1) begin errors++; $display("FAIL nest_outer_ret: got act=%b ie=%b expected act=0 ie=1", INT_ACTIVE, IE); end
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b1 || INT_VECTOR !== 16'h001C) begin errors++; $display("FAIL nest_after: got ld=%b vec=%h expected ld=1 vec=001c", PC_LD_INTX, INT_VECTOR); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b1);
    $display("nesting: preempt 0010, pops, then 001c");
  endtask
`else
  task automatic test_single_level();
    pulse_int(4'b0100);
    do_commit(1'b0, 1'b0, 1'b0);
    cyc();
    pulse_int(4'b0001);
    do_commit(1'b1, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b0 || ACTIVE_ID !== 2'd2) begin errors++; $display("FAIL single_no_preempt: got ld=%b id=%0d expected ld=0 id=2", PC_LD_INTX, ACTIVE_ID); end
    do_commit(1'b0, 1'b0, 1'b1);
    checks++; if (INT_ACTIVE !== 1'b0 || PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL single_ret: got act=%b ld=%b expected act=0 ld=0", INT_ACTIVE, PC_LD_INTX); end
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b1 || INT_VECTOR !== 16'h0010) begin errors++; $display("FAIL single_after: got ld=%b vec=%h expected ld=1 vec=0010", PC_LD_INTX, INT_VECTOR); end
    cyc();
    do_commit(1'b0, 1'b0, 1'b1);
    $display("single level: no preemption, 0010 after return");
  endtask
`endif

  task automatic test_reset_mid_service();
    write_mask(4'b0010);
    pulse_int(4'b1010);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (ACTIVE_ID !== 2'd1 || PENDING !== 4'b1000) begin errors++; $display("FAIL rstmid_setup: got id=%0d pend=%b expected id=1 pend=1000", ACTIVE_ID, PENDING); end
    cyc();
    #2 RESET = 1'b0;
    #1;
    checks++; if (INT_ACTIVE !== 1'b0 || ACTIVE_ID !== 2'd0 || PENDING !== 4'b0000 || IE !== 1'b0) begin errors++; $display("FAIL rstmid_async: got act=%b id=%0d pend=%b ie=%b expected all 0", INT_ACTIVE, ACTIVE_ID, PENDING, IE); end
    @(posedge CLK);
    #1 RESET = 1'b1;
    cyc();
    do_commit(1'b0, 1'b0, 1'b0);
    do_commit(1'b1, 1'b0, 1'b0);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b0) begin errors++; $display("FAIL rstmid_no_ld: got %b expected 0", PC_LD_INTX); end
    pulse_int(4'b0001);
    do_commit(1'b0, 1'b0, 1'b0);
    checks++; if (PC_LD_INTX !== 1'b1 || INT_VECTOR !== 16'h0010) begin errors++; $display("FAIL rstmid_mask_ones: got ld=%b vec=%h expected ld=1 vec=0010", PC_LD_INTX, INT_VECTOR); end
    cyc();
    $display("reset mid service: abandoned, mask back to all ones");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_entry();
    test_priority();
    test_mask();
    test_level_hold();
    test_back_to_back();
`ifdef INT_NESTING_EN
    test_nesting();
`else
    test_single_level();
`endif
    test_reset_mid_service();
    checks++; if (consec_count !== 0) begin errors++; $display("FAIL ld_never_consecutive: got %0d pairs expected 0", consec_count); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
